muldiv_sequencer: RTL and testbench

- Iterative multi-cycle multiply/divide unit for the RV32M instructions, sitting beside the single-cycle ALU in the EX stage.
- Accepts one operation per start handshake and runs one shift-add or restoring-subtract step per cycle.
- Holds the pipeline through a stall output until the result is ready.
- Decode asserts start when the EX-stage instruction has opcode 0110011 and funct7 0000001, and passes funct3 unchanged.

---
 rtl/muldiv_sequencer.sv | 164 ++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative RV32M multiply/divide sequencer with pipeline stall
module muldiv_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);

  state_t           state_q, state_d;
  logic [2:0]       f3_q, f3_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic [XLEN-1:0]  acc_q, acc_d;       // product upper half / partial remainder
  logic [XLEN-1:0]  lo_q, lo_d;         // multiplier / quotient
  logic [XLEN-1:0]  mcand_q, mcand_d;   // multiplicand / divisor magnitude
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  result_q, result_d;

  // Operand decode for a new request: signedness, magnitudes and fast-path cases.
  logic            is_div, signed_a, signed_b, in_sa, in_sb;
  logic [XLEN-1:0] mag_a, mag_b, fast_res;
  logic            div_zero, div_ovf, take_new;

  always_comb begin
    is_div   = funct3[2];
    signed_a = (funct3 == 3'b001) | (funct3 == 3'b010) | (funct3 == 3'b100) | (funct3 == 3'b110);
    signed_b = (funct3 == 3'b001) | (funct3 == 3'b100) | (funct3 == 3'b110);
    in_sa    = signed_a & op_a[XLEN-1];
    in_sb    = signed_b & op_b[XLEN-1];
    mag_a    = in_sa ? (~op_a + 1'b1) : op_a;
    mag_b    = in_sb ? (~op_b + 1'b1) : op_b;
    div_zero = is_div & (op_b == '0);
    div_ovf  = is_div & ~funct3[0] & (op_a == MIN_NEG) & (op_b == '1);
    if (div_zero) fast_res = funct3[1] ? op_a : '1;
    else          fast_res = funct3[1] ? '0 : op_a;
    take_new = start & ~kill & ((state_q == S_IDLE) | (state_q == S_DONE));
  end

  // One iteration step of shift-add multiply and restoring divide.
  logic [XLEN:0]     mul_sum, rem_sh, rem_sub;
  logic              rem_ge;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, fix_res;

  always_comb begin
    mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    rem_sh   = {acc_q, lo_q[XLEN-1]};
    rem_sub  = rem_sh - {1'b0, mcand_q};
    rem_ge   = rem_sh >= {1'b0, mcand_q};
    prod     = {acc_q, lo_q};
    prod_fix = (sign_a_q ^ sign_b_q) ? (~prod + 1'b1) : prod;
    quot_fix = (sign_a_q ^ sign_b_q) ? (~lo_q + 1'b1) : lo_q;
    rem_fix  = sign_a_q ? (~acc_q + 1'b1) : acc_q;
    case (f3_q)
      3'b000:                   fix_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011:   fix_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:           fix_res = quot_fix;
      default:                  fix_res = rem_fix;
    endcase
  end

  // Next-state and datapath update; kill overrides everything and keeps the result.
  always_comb begin
    state_d  = state_q;
    f3_d     = f3_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    mcand_d  = mcand_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    if (kill) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (take_new) begin
            if (div_zero | div_ovf) begin
              result_d = fast_res;
              state_d  = S_DONE;
            end else begin
              f3_d     = funct3;
              sign_a_d = in_sa;
              sign_b_d = in_sb;
              acc_d    = '0;
              lo_d     = is_div ? mag_a : mag_b;
              mcand_d  = is_div ? mag_b : mag_a;
              cnt_d    = '0;
              state_d  = S_CALC;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_CALC: begin
          if (f3_q[2]) begin
            acc_d = rem_ge ? rem_sub[XLEN-1:0] : rem_sh[XLEN-1:0];
            lo_d  = {lo_q[XLEN-2:0], rem_ge};
          end else begin
            acc_d = mul_sum[XLEN:1];
            lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) state_d = S_FIX;
        end
        S_FIX: begin
          result_d = fix_res;
          state_d  = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      f3_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      acc_q    <= '0;
      lo_q     <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      f3_q     <= f3_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      mcand_q  <= mcand_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Status outputs; stall covers the request cycle so the pipeline freezes at once.
  always_comb begin
    busy   = (state_q == S_CALC) | (state_q == S_FIX);
    done   = (state_q == S_DONE);
    stall  = busy | (start & ~kill & (state_q == S_IDLE));
    result = result_q;
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - scoreboard bench for muldiv_sequencer
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        kill;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] result;

  logic [31:0] exp_q[$];
  logic [31:0] last_exp;
  int          n_cmp = 0;
  int          n_bad = 0;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .kill(kill), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .busy(busy), .stall(stall), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference: RV32M semantics from plain 64-bit / 32-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    int          ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    ia = $signed(a);
    ib = $signed(b);
    case (f)
      3'd0: begin p = 64'(ua * ub); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(ia / ib);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Monitor: every done cycle must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got result %h want no done", result);
      end else begin
        check("result", result, exp_q.pop_front());
      end
    end
  end

  // Issue one op (called #1 after a posedge, with the DUT in IDLE or DONE) and wait for done.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input bit from_done);
    int lat, stalls;
    bit fast;
    fast = is_fast(f, a, b);
    funct3 = f; op_a = a; op_b = b; start = 1'b1;
    exp_q.push_back(model(f, a, b));
    last_exp = model(f, a, b);
    #1;
    stalls = stall ? 1 : 0;
    @(posedge clk); #1;
    start = 1'b0; op_a = $urandom; op_b = $urandom; funct3 = 3'($urandom);
    lat = 1;
    while (!done && lat < 100) begin
      if (stall) stalls++;
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, fast ? 1 : 34);
    check("stall_cycles", stalls, (from_done ? 0 : 1) + (fast ? 0 : 33));
    check("busy_in_done", {31'b0, busy}, 32'h0);
  endtask

  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    run_op(f, a, b, 1'b0);
    @(posedge clk); #1;
    check("done_width", {31'b0, done}, 32'h0);
    check("result_held", result, last_exp);
  endtask

  logic [2:0]  d_f[12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
  logic [31:0] d_a[12] = '{32'd7, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                           32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
  logic [31:0] d_b[12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000, 32'd2, 32'd2, 32'd2,
                           32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

  initial begin
    #5ms;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; start = 1'b0; kill = 1'b0; funct3 = '0; op_a = '0; op_b = '0; last_exp = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_done", {31'b0, done}, 32'h0);
    check("reset_stall", {31'b0, stall}, 32'h0);
    check("reset_result", result, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) do_op(d_f[i], d_a[i], d_b[i]);

    // kill at the 10th CALC edge: no done, result held
    funct3 = 3'd3; op_a = 32'h1234_5678; op_b = 32'h9ABC_DEF0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("busy_before_kill", {31'b0, busy}, 32'h1);
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check("kill_busy", {31'b0, busy}, 32'h0);
    check("kill_done", {31'b0, done}, 32'h0);
    check("kill_result", result, last_exp);
    repeat (40) @(posedge clk);
    #1;
    check("kill_result_later", result, last_exp);
    do_op(3'd3, 32'd3, 32'd5);

    // kill beats a same-cycle start
    funct3 = 3'd0; op_a = 32'd9; op_b = 32'd9; start = 1'b1; kill = 1'b1;
    #1;
    check("kill_start_stall", {31'b0, stall}, 32'h0);
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    check("kill_start_busy", {31'b0, busy}, 32'h0);
    check("kill_start_done", {31'b0, done}, 32'h0);

    // back-to-back: new MUL accepted in the DONE cycle
    run_op(3'd5, 32'd1000, 32'd3, 1'b0);
    check("done_cycle_stall", {31'b0, stall}, 32'h0);
    run_op(3'd0, 32'd6, 32'd7, 1'b1);
    @(posedge clk); #1;
    check("b2b_result", result, 32'd42);

    // fast path chained from DONE
    run_op(3'd4, 32'd8, 32'd0, 1'b0);
    run_op(3'd7, 32'd9, 32'd0, 1'b1);
    @(posedge clk); #1;

    // asynchronous reset in the middle of CALC
    funct3 = 3'd1; op_a = 32'hDEAD_BEEF; op_b = 32'h1357_9BDF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("arst_busy", {31'b0, busy}, 32'h0);
    check("arst_done", {31'b0, done}, 32'h0);
    check("arst_result", result, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    last_exp = '0;
    @(posedge clk); #1;

    // randomized ops with biased corner operands
    for (int i = 0; i < 150; i++) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      int          mode;
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      mode = $urandom_range(0, 5);
      if (mode == 0) b = 32'h0;
      else if (mode == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (mode == 2) begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
      else if (mode == 3) b = b | 32'h8000_0000;
      do_op(f, a, b);
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
